// File: rtl/ct_piu_l2pmp_apb_mst.sv
// ct_piu_l2pmp_apb_mst
//
// APB initiator bridging the PIU register path to the L2 PMP configuration
// slave. Accepts one access at a time on a valid/ready request port, runs a
// two-phase APB transfer (SETUP, ACCESS), and returns read data and an error
// flag as a single-cycle response pulse. A watchdog forces completion with an
// error when the slave holds pready low for TIMEOUT ACCESS cycles.
//
// State table:
//   IDLE   | waiting for a request; req_rdy high
//   SETUP  | APB setup phase; psel high, penable low
//   ACCESS | APB access phase; waiting for pready or watchdog expiry
//   RESP   | resp_vld pulse with captured data/error
//
// Ports:
//   forever_cpuclk, cpurst           clock, synchronous active-high reset
//   req_vld/req_rdy/req_write/
//   req_addr/req_wdata               request port
//   resp_vld/resp_rdata/resp_err     response pulse
//   psel/penable/pwrite/paddr/pwdata APB initiator outputs (*_l2pmp_x)
//   pready/perr/x_prdata_l2pmp       APB slave returns
module ct_piu_l2pmp_apb_mst #(
    parameter int ADDR_WIDTH = 12,
    parameter int TIMEOUT    = 255
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_vld,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  psel_l2pmp_x,
    output logic                  penable_l2pmp_x,
    output logic                  pwrite_l2pmp_x,
    output logic [ADDR_WIDTH-1:0] paddr_l2pmp_x,
    output logic [31:0]           pwdata_l2pmp_x,
    input  logic                  pready_l2pmp_x,
    input  logic                  perr_l2pmp_x,
    input  logic [31:0]           x_prdata_l2pmp
);

    // A zero TIMEOUT disables the watchdog; keep a 1-bit counter so the
    // declarations stay legal.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                  state_q,  state_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q,  paddr_d;
    logic [31:0]             pwdata_q, pwdata_d;
    logic [31:0]             rdata_q,  rdata_d;
    logic                    err_q,    err_d;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_vld) begin
                    pwrite_d = req_write;
                    paddr_d  = req_addr;
                    pwdata_d = req_wdata;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready_l2pmp_x) begin
                    // Read data is only meaningful for an error-free read.
                    rdata_d = (!pwrite_q && !perr_l2pmp_x) ? x_prdata_l2pmp : 32'd0;
                    err_d   = perr_l2pmp_x;
                    state_d = ST_RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Every output is a flop or a decode of the state register, so slave
    // inputs never reach an output combinationally.
    assign req_rdy         = (state_q == ST_IDLE);
    assign resp_vld        = (state_q == ST_RESP);
    assign resp_rdata      = rdata_q;
    assign resp_err        = err_q;
    assign psel_l2pmp_x    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign penable_l2pmp_x = (state_q == ST_ACCESS);
    assign pwrite_l2pmp_x  = pwrite_q;
    assign paddr_l2pmp_x   = paddr_q;
    assign pwdata_l2pmp_x  = pwdata_q;

endmodule
